// File: rtl/counter_dir_ctrl.sv
// Turnaround controller for an up/down counter: sweeps between LO and HI,
// stalls the counter for DWELL cycles at each limit and counts reversals.
module counter_dir_ctrl #(
    parameter logic [8:0]  LO    = 9'd0,
    parameter logic [8:0]  HI    = 9'd255,
    parameter int unsigned DWELL = 4        // legal 1..15, LO < HI
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] count,
    input  logic       run,
    output logic       dir,
    output logic       hold,
    output logic       top_pulse,
    output logic       bot_pulse,
    output logic [7:0] turns
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_UP       = 3'd1,
        ST_DWELL_HI = 3'd2,
        ST_DOWN     = 3'd3,
        ST_DWELL_LO = 3'd4
    } state_t;

    localparam logic [3:0] DWELL_LOAD = 4'(DWELL - 1);

    state_t     r_state;
    logic [3:0] r_dwell;
    logic       r_dir;
    logic       r_hold;
    logic       r_top;
    logic       r_bot;
    logic [7:0] r_turns;

    state_t     w_state_nxt;
    logic [3:0] w_dwell_nxt;
    logic       w_dir_nxt;
    logic       w_hold_nxt;
    logic       w_top_nxt;
    logic       w_bot_nxt;
    logic [7:0] w_turns_nxt;
    logic       w_hit_hi;
    logic       w_hit_lo;
    logic [7:0] w_turns_inc;

    assign w_hit_hi    = (count >= HI);
    assign w_hit_lo    = (count <= LO);
    assign w_turns_inc = (r_turns == 8'hFF) ? r_turns : r_turns + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_dir_nxt   = r_dir;
        w_hold_nxt  = r_hold;
        w_top_nxt   = 1'b0;
        w_bot_nxt   = 1'b0;
        w_turns_nxt = r_turns;

        // A stopped controller freezes everything; a pending limit hit is
        // simply seen again once run comes back.
        if (r_state != ST_IDLE && !run) begin
            w_hold_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_dir_nxt  = 1'b1;
                    w_hold_nxt = 1'b1;
                    if (run) begin
                        w_state_nxt = ST_UP;
                        w_hold_nxt  = 1'b0;
                    end
                end
                ST_UP: begin
                    w_dir_nxt  = 1'b1;
                    w_hold_nxt = 1'b0;
                    if (w_hit_hi) begin
                        w_state_nxt = ST_DWELL_HI;
                        w_hold_nxt  = 1'b1;
                        w_top_nxt   = 1'b1;
                        w_dwell_nxt = DWELL_LOAD;
                    end
                end
                ST_DWELL_HI: begin
                    w_dir_nxt  = 1'b1;
                    w_hold_nxt = 1'b1;
                    if (r_dwell == 4'd0) begin
                        w_state_nxt = ST_DOWN;
                        w_dir_nxt   = 1'b0;
                        w_hold_nxt  = 1'b0;
                        w_turns_nxt = w_turns_inc;
                    end else begin
                        w_dwell_nxt = r_dwell - 4'd1;
                    end
                end
                ST_DOWN: begin
                    w_dir_nxt  = 1'b0;
                    w_hold_nxt = 1'b0;
                    if (w_hit_lo) begin
                        w_state_nxt = ST_DWELL_LO;
                        w_hold_nxt  = 1'b1;
                        w_bot_nxt   = 1'b1;
                        w_dwell_nxt = DWELL_LOAD;
                    end
                end
                ST_DWELL_LO: begin
                    w_dir_nxt  = 1'b0;
                    w_hold_nxt = 1'b1;
                    if (r_dwell == 4'd0) begin
                        w_state_nxt = ST_UP;
                        w_dir_nxt   = 1'b1;
                        w_hold_nxt  = 1'b0;
                        w_turns_nxt = w_turns_inc;
                    end else begin
                        w_dwell_nxt = r_dwell - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_dir_nxt   = 1'b1;
                    w_hold_nxt  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_dwell <= 4'd0;
            r_dir   <= 1'b1;
            r_hold  <= 1'b1;
            r_top   <= 1'b0;
            r_bot   <= 1'b0;
            r_turns <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_dwell <= w_dwell_nxt;
            r_dir   <= w_dir_nxt;
            r_hold  <= w_hold_nxt;
            r_top   <= w_top_nxt;
            r_bot   <= w_bot_nxt;
            r_turns <= w_turns_nxt;
        end
    end

    assign dir       = r_dir;
    assign hold      = r_hold;
    assign top_pulse = r_top;
    assign bot_pulse = r_bot;
    assign turns     = r_turns;

endmodule

// File: doc/counter_dir_ctrl.md
COUNTER_DIR_CTRL -- requirements
Module: counter_dir_ctrl

Interface
REQ-001 Parameters SHALL be as follows.
- LO, default 9'd0: lower turnaround limit.
- HI, default 9'd255: upper turnaround limit.
- DWELL, default 4: number of hold cycles at each limit, legal range 1..15.
- Legal configurations require LO < HI.
REQ-002 Ports SHALL be, in order:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: one clock; reset is asynchronous and active-low.
- count, input, 9: current value from the up/down counter stage.
- run, input, 1: enable; when low, the controller freezes.
- dir, output, 1: direction to the counter, 1 = up, 0 = down.
- hold, output, 1: counter-stall request, 1 = counter must not advance.
- top_pulse, output, 1: one-cycle strobe on reaching HI.
- bot_pulse, output, 1: one-cycle strobe on reaching LO.
- turns, output, 8: saturating count of completed direction reversals.
REQ-003 All outputs SHALL be registered, with no combinational path from count or run to any output.

Function
REQ-004 The FSM SHALL have exactly five states: IDLE, UP, DWELL_HI, DOWN, DWELL_LO.
REQ-005 IDLE: dir=1 and hold=1; the first rising edge with run=1 SHALL move to UP, with hold=0 visible in the next cycle.
REQ-006 UP: dir=1, hold=0. An edge sampling count >= HI SHALL enter DWELL_HI, set hold=1, assert top_pulse for exactly one cycle, and load the dwell counter with DWELL-1.
REQ-007 DWELL_HI: hold=1, dir stays 1. Each edge SHALL decrement the dwell counter. The edge sampling dwell counter==0 SHALL enter DOWN, set dir=0 and hold=0, and increment turns. Hold is therefore high for exactly DWELL cycles.
REQ-008 DOWN: dir=0, hold=0. An edge sampling count <= LO SHALL enter DWELL_LO, set hold=1, assert bot_pulse for one cycle, and load DWELL-1.
REQ-009 DWELL_LO SHALL mirror DWELL_HI: hold for DWELL cycles, then enter UP with dir=1, hold=0, and increment turns.
REQ-010 Comparisons SHALL be unsigned 9-bit. A count already beyond a limit on entry to UP or DOWN (count > HI in UP, count < LO in DOWN) SHALL be treated as a hit on the next edge.
REQ-011 In UP only the HI compare SHALL be evaluated; in DOWN only the LO compare. Dwell states SHALL ignore count.
REQ-012 turns SHALL saturate at 8'd255 and never wrap.
REQ-013 run=0 in any non-IDLE state SHALL, from the next cycle:
- force hold=1;
- freeze the state, dwell counter, dir and turns;
- suppress top_pulse and bot_pulse.
REQ-014 When run returns high, operation SHALL resume from the frozen state and dwell value; hold returns to that state's value on the cycle after run is sampled high.
REQ-015 When a limit hit and run=0 are sampled on the same edge, the freeze SHALL take priority: no transition and no pulse. The hit is re-evaluated after resume.
REQ-016 top_pulse and bot_pulse SHALL never be high in the same cycle and SHALL each be high for at most one cycle per limit arrival.

Reset
REQ-017 reset low SHALL immediately and asynchronously force:
- state=IDLE, dir=1, hold=1;
- top_pulse=0, bot_pulse=0, turns=0, dwell counter=0.
REQ-018 Reset asserted mid-dwell or mid-sweep SHALL discard all progress. After release, the block SHALL wait in IDLE for run=1.
REQ-019 Reset release SHALL take effect on the first rising clk edge after reset goes high. No transition out of IDLE occurs before that edge.

Verification
REQ-020 Default parameters, run=1, count driven 0->255 by a model counter honouring dir/hold:
- top_pulse on the cycle after count=255 is sampled;
- hold high for 4 cycles;
- then dir=0 and turns=1.
REQ-021 Full cycle 0->255->0 with default parameters: bot_pulse fires once at count=0, then dir=1 and turns=2. Confirm no double pulses.
REQ-022 LO=9'd10, HI=9'd20, DWELL=1; inject count=25 while in UP -> DWELL_HI entered on the next edge, hold high for exactly 1 cycle.
REQ-023 Drop run for 3 cycles during DWELL_LO with 2 dwell cycles remaining:
- hold stays 1 and no pulses occur;
- after run returns, exactly 2 further hold cycles, then dir=1.
REQ-024 Assert reset low mid-DOWN with turns=7 -> immediately dir=1, hold=1, turns=0, state IDLE. With run held high, UP is re-entered on the first edge after release.
REQ-025 Force 300 reversals with LO=0, HI=1, DWELL=1 -> turns holds at 255 thereafter.
